recfn_to_int_pipe: RTL

- Two-stage pipelined converter from 33-bit recoded single-precision (recFN, exp 8 / sig 24) to a signed or unsigned OUT_W-bit integer.
- Implements RISC-V FCVT.W[U]/L[U].S semantics: rounding mode, saturation and exception flags.
- It is the reverse path to the raw-to-recFN rounding wrapper in the FPU: that path produces recFN, and this block consumes recFN for integer writeback.
- Valid/ready on both sides.

---
 rtl/recfn_to_int_pipe.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/recfn_to_int_pipe.sv
// Two-stage recFN (33-bit single) to OUT_W-bit integer converter with RISC-V FCVT rounding/saturation.
// Optional FCLASS output enabled by defining RECFN_TO_INT_CLASS_EN.
module recfn_to_int_pipe #(
  parameter int OUT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32:0]      in_rec,
  input  logic [2:0]       in_rm,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_int,
  output logic [4:0]       out_flags
`ifdef RECFN_TO_INT_CLASS_EN
  ,
  output logic [9:0]       out_class
`endif
);

  localparam int MW = OUT_W + 1;
  localparam int FW = OUT_W + 25;
  localparam logic signed [9:0] EMAX = 10'(OUT_W);

  logic                w_s1Adv;
  logic                w_s2Adv;
  logic                w_sign;
  logic [8:0]          w_exp;
  logic [22:0]         w_sig;
  logic                w_isZero;
  logic                w_isInf;
  logic                w_isNan;
  logic signed [9:0]   w_e;
  logic                w_ovf;
  logic [6:0]          w_shamt;
  logic [FW-1:0]       w_field;
  logic [MW-1:0]       w_mag;
  logic                w_rnd;
  logic                w_stk;

  logic                r_s1Valid;
  logic                r_s1Sign;
  logic [2:0]          r_s1Rm;
  logic                r_s1Signed;
  logic [MW-1:0]       r_s1Mag;
  logic                r_s1Rnd;
  logic                r_s1Stk;
  logic                r_s1Nan;
  logic                r_s1Inf;
  logic                r_s1Ovf;

  logic [2:0]          w_rm;
  logic                w_inc;
  logic [MW:0]         w_rmag;
  logic [OUT_W-1:0]    w_lowMag;
  logic [OUT_W-1:0]    w_negRes;
  logic                w_rangeErr;
  logic                w_invalid;
  logic                w_posSat;
  logic [OUT_W-1:0]    w_result;
  logic [4:0]          w_flags;

  logic                r_s2Valid;
  logic [OUT_W-1:0]    r_outInt;
  logic [4:0]          r_outFlags;

  assign w_s2Adv  = !r_s2Valid || out_ready;
  assign w_s1Adv  = !r_s1Valid || w_s2Adv;
  assign in_ready = w_s1Adv;

  assign w_sign   = in_rec[32];
  assign w_exp    = in_rec[31:23];
  assign w_sig    = in_rec[22:0];
  assign w_isZero = (w_exp[8:6] == 3'b000);
  assign w_isInf  = (w_exp[8:6] == 3'b110);
  assign w_isNan  = (w_exp[8:6] == 3'b111);
  assign w_e      = $signed({1'b0, w_exp}) - 10'sd256;
  assign w_ovf    = !w_isZero && !w_isInf && !w_isNan && (w_e > EMAX);

  // Field holds value * 2^24: integer part above bit 24, round bit at 23, sticky below.
  assign w_shamt  = w_e[6:0] + 7'd1;
  assign w_field  = {{(FW-24){1'b0}}, 1'b1, w_sig} << w_shamt;

  always_comb begin
    w_mag = '0;
    w_rnd = 1'b0;
    w_stk = 1'b0;
    if (!w_isZero && !w_isInf && !w_isNan && !w_ovf) begin
      if (w_e < -10'sd1) begin
        w_stk = 1'b1;
      end else begin
        w_mag = w_field[FW-1:24];
        w_rnd = w_field[23];
        w_stk = |w_field[22:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Valid  <= 1'b0;
      r_s1Sign   <= 1'b0;
      r_s1Rm     <= 3'd0;
      r_s1Signed <= 1'b0;
      r_s1Mag    <= '0;
      r_s1Rnd    <= 1'b0;
      r_s1Stk    <= 1'b0;
      r_s1Nan    <= 1'b0;
      r_s1Inf    <= 1'b0;
      r_s1Ovf    <= 1'b0;
    end else if (w_s1Adv) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Sign   <= w_sign;
        r_s1Rm     <= in_rm;
        r_s1Signed <= in_signed;
        r_s1Mag    <= w_mag;
        r_s1Rnd    <= w_rnd;
        r_s1Stk    <= w_stk;
        r_s1Nan    <= w_isNan;
        r_s1Inf    <= w_isInf;
        r_s1Ovf    <= w_ovf;
      end
    end
  end

  assign w_rm = (r_s1Rm > 3'd4) ? 3'd0 : r_s1Rm;

  always_comb begin
    w_inc = 1'b0;
    case (w_rm)
      3'd0:    w_inc = r_s1Rnd && (r_s1Stk || r_s1Mag[0]);
      3'd2:    w_inc = r_s1Sign && (r_s1Rnd || r_s1Stk);
      3'd3:    w_inc = !r_s1Sign && (r_s1Rnd || r_s1Stk);
      3'd4:    w_inc = r_s1Rnd;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_rmag   = {1'b0, r_s1Mag} + {{MW{1'b0}}, w_inc};
  assign w_lowMag = w_rmag[OUT_W-1:0];
  assign w_negRes = -w_lowMag;

  // Negative signed results may reach exactly 2^(OUT_W-1); unsigned negatives must round to zero.
  always_comb begin
    w_rangeErr = 1'b0;
    if (r_s1Signed) begin
      if (r_s1Sign)
        w_rangeErr = (|w_rmag[MW:OUT_W]) || (w_rmag[OUT_W-1] && (|w_rmag[OUT_W-2:0]));
      else
        w_rangeErr = |w_rmag[MW:OUT_W-1];
    end else begin
      if (r_s1Sign)
        w_rangeErr = |w_rmag;
      else
        w_rangeErr = |w_rmag[MW:OUT_W];
    end
  end

  assign w_invalid = r_s1Nan || r_s1Inf || r_s1Ovf || w_rangeErr;
  assign w_posSat  = r_s1Nan || !r_s1Sign;

  always_comb begin
    w_result = r_s1Sign ? w_negRes : w_lowMag;
    if (w_invalid) begin
      if (r_s1Signed)
        w_result = w_posSat ? {1'b0, {(OUT_W-1){1'b1}}} : {1'b1, {(OUT_W-1){1'b0}}};
      else
        w_result = w_posSat ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    end
    w_flags = {w_invalid, 3'b000, !w_invalid && (r_s1Rnd || r_s1Stk)};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2Valid  <= 1'b0;
      r_outInt   <= '0;
      r_outFlags <= 5'd0;
    end else if (w_s2Adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outInt   <= w_result;
        r_outFlags <= w_flags;
      end
    end
  end

  assign out_valid = r_s2Valid;
  assign out_int   = r_outInt;
  assign out_flags = r_outFlags;

`ifdef RECFN_TO_INT_CLASS_EN
  logic [9:0] w_class;
  logic [9:0] r_s1Class;
  logic [9:0] r_outClass;

  // Recoded subnormals keep a normalised significand but sit in exponents 0x06B..0x081.
  always_comb begin
    w_class = 10'd0;
    if (w_isNan)
      w_class[w_sig[22] ? 9 : 8] = 1'b1;
    else if (w_isInf)
      w_class[w_sign ? 0 : 7] = 1'b1;
    else if (w_isZero)
      w_class[w_sign ? 3 : 4] = 1'b1;
    else if (w_exp <= 9'h081)
      w_class[w_sign ? 2 : 5] = 1'b1;
    else
      w_class[w_sign ? 1 : 6] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Class  <= 10'd0;
      r_outClass <= 10'd0;
    end else begin
      if (w_s1Adv && in_valid)
        r_s1Class <= w_class;
      if (w_s2Adv && r_s1Valid)
        r_outClass <= r_s1Class;
    end
  end

  assign out_class = r_outClass;
`endif

endmodule
